rx_word_deserializer: RTL and testbench

//   Parametrised serial-to-parallel converter for the UART receive path.

---
 rtl/rx_word_deserializer_if.sv | 40 ++++
 rtl/rx_word_deserializer.sv | 91 +++++++++
 tb/tb_rx_word_deserializer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_word_deserializer_if.sv
// ---------------------------------------------------------------------------
// rx_word_deserializer_if
//   Bundles the serial-in / word-out signals of the UART RX deserializer.
//   master : the side that feeds sampled bits and consumes completed words
//            (sampler + RX FSM, or a testbench).
//   slave  : the deserializer itself.
//   Signals
//     clr          abort the partial word, restart the bit count
//     deser_en     shift sampled_bit in on this edge
//     sampled_bit  serial data bit from the sampler
//     P_DATA       last completed word, held until the next completion
//     data_valid   one-cycle strobe when P_DATA/par_bit update
//     par_bit      parity of P_DATA, held with P_DATA
//     bit_cnt      bits captured in the current partial word
//     busy         high while bit_cnt != 0
// ---------------------------------------------------------------------------
interface rx_word_deserializer_if #(
   parameter int DATA_WIDTH = 8
);
   localparam int CNT_W = $clog2(DATA_WIDTH);

   logic                  clr;
   logic                  deser_en;
   logic                  sampled_bit;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  par_bit;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  busy;

   modport master (
      output clr, deser_en, sampled_bit,
      input  P_DATA, data_valid, par_bit, bit_cnt, busy
   );

   modport slave (
      input  clr, deser_en, sampled_bit,
      output P_DATA, data_valid, par_bit, bit_cnt, busy
   );
endinterface

// File: rtl/rx_word_deserializer.sv
// ---------------------------------------------------------------------------
// rx_word_deserializer
//   Serial-to-parallel converter for the UART receive path. Collects
//   DATA_WIDTH sampled bits (LSB- or MSB-first), then publishes the word on a
//   held register together with its parity bit and a one-cycle valid strobe.
//   Ports
//     clk    system clock, rising edge
//     reset  synchronous, active-high; clears every register
//     bus    rx_word_deserializer_if.slave (clr, deser_en, sampled_bit in;
//            P_DATA, data_valid, par_bit, bit_cnt, busy out)
//   Priority on each edge: reset > clr > deser_en.
// ---------------------------------------------------------------------------
module rx_word_deserializer #(
   parameter int DATA_WIDTH = 8,
   parameter int LSB_FIRST  = 1,
   parameter int PAR_ODD    = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   rx_word_deserializer_if.slave   bus
);
   localparam int   CNT_W   = $clog2(DATA_WIDTH);
   localparam logic PAR_INV = (PAR_ODD != 0);

   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  par_q, par_d;
   logic                  valid_q, valid_d;

   logic [DATA_WIDTH-1:0] shifted;
   logic                  last_bit;

   // Shift direction decides where the first received bit ends up once the
   // word is complete: LSB-first shifts right from the top, MSB-first left.
   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign shifted = {bus.sampled_bit, sh_q[DATA_WIDTH-1:1]};
      end else begin : g_msb_first
         assign shifted = {sh_q[DATA_WIDTH-2:0], bus.sampled_bit};
      end
   endgenerate

   assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));

   always_comb begin
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      par_d   = par_q;
      valid_d = 1'b0;
      if (bus.clr) begin
         // Abort: the output word and its parity stay as they were.
         sh_d  = '0;
         cnt_d = '0;
      end else if (bus.deser_en) begin
         sh_d = shifted;
         if (last_bit) begin
            // Publish the word including the bit arriving on this edge.
            data_d  = shifted;
            par_d   = (^shifted) ^ PAR_INV;
            cnt_d   = '0;
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         par_q   <= par_d;
         valid_q <= valid_d;
      end
   end

   assign bus.P_DATA     = data_q;
   assign bus.par_bit    = par_q;
   assign bus.data_valid = valid_q;
   assign bus.bit_cnt    = cnt_q;
   assign bus.busy       = (cnt_q != '0);
endmodule

// File: tb/tb_rx_word_deserializer.sv
// ---------------------------------------------------------------------------
// tb_rx_word_deserializer
//   Three deserializer instances share one serial stimulus:
//     u_lsb : LSB_FIRST=1, PAR_ODD=0
//     u_msb : LSB_FIRST=0, PAR_ODD=0
//     u_odd : LSB_FIRST=1, PAR_ODD=1
//   Every bit sent is recorded by a bit-list model; when eight bits have been
//   recorded the expected word/parity for each configuration is pushed to a
//   scoreboard, which a monitor pops whenever a data_valid strobe appears.
// ---------------------------------------------------------------------------
module tb_rx_word_deserializer;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] d_lsb;
      logic         p_lsb;
      logic [W-1:0] d_msb;
      logic         p_msb;
      logic         p_odd;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clr_r = 1'b0;
   logic en_r = 1'b0;
   logic bit_r = 1'b0;

   int pass_cnt = 0;
   int total_cnt = 0;
   int strobe_cnt = 0;
   int cyc = 0;
   int strobe_cyc[$];
   exp_t exp_q[$];
   logic cur_bits[$];

   always #5 clk = ~clk;

   rx_word_deserializer_if #(.DATA_WIDTH(W)) if_lsb ();
   rx_word_deserializer_if #(.DATA_WIDTH(W)) if_msb ();
   rx_word_deserializer_if #(.DATA_WIDTH(W)) if_odd ();

   assign if_lsb.clr = clr_r;  assign if_lsb.deser_en = en_r;  assign if_lsb.sampled_bit = bit_r;
   assign if_msb.clr = clr_r;  assign if_msb.deser_en = en_r;  assign if_msb.sampled_bit = bit_r;
   assign if_odd.clr = clr_r;  assign if_odd.deser_en = en_r;  assign if_odd.sampled_bit = bit_r;

   rx_word_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(1), .PAR_ODD(0)) u_lsb (
      .clk(clk), .reset(reset), .bus(if_lsb.slave));
   rx_word_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(0), .PAR_ODD(0)) u_msb (
      .clk(clk), .reset(reset), .bus(if_msb.slave));
   rx_word_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(1), .PAR_ODD(1)) u_odd (
      .clk(clk), .reset(reset), .bus(if_odd.slave));

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      en_r = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Record one bit in the model; on the eighth bit compute expectations.
   task automatic model_bit(input logic b);
      exp_t e;
      logic [W-1:0] wl, wm;
      cur_bits.push_back(b);
      if (cur_bits.size() == W) begin
         for (int i = 0; i < W; i++) begin
            wl[i]       = cur_bits[i];
            wm[W-1-i]   = cur_bits[i];
         end
         e.d_lsb = wl;
         e.p_lsb = ^wl;
         e.d_msb = wm;
         e.p_msb = ^wm;
         e.p_odd = ~(^wl);
         exp_q.push_back(e);
         cur_bits.delete();
      end
   endtask

   task automatic send_bit(input logic b);
      en_r  = 1'b1;
      bit_r = b;
      cycle();
      en_r  = 1'b0;
      model_bit(b);
   endtask

   task automatic send_word_lsb(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) send_bit(w[i]);
   endtask

   // ---------------- scoreboard monitor ----------------
   task automatic monitor();
      exp_t e;
      logic vl, vm, vo;
      forever begin
         @(negedge clk);
         cyc++;
         vl = if_lsb.data_valid;
         vm = if_msb.data_valid;
         vo = if_odd.data_valid;
         if (vl || vm || vo) begin
            strobe_cnt++;
            strobe_cyc.push_back(cyc);
            total_cnt++;
            if (!(vl && vm && vo))
               $display("FAIL strobe_align: valid lsb/msb/odd=%b%b%b required 111", vl, vm, vo);
            else pass_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_strobe: strobe at cycle %0d with empty scoreboard", cyc);
            end else begin
               pass_cnt++;
               e = exp_q.pop_front();
               total_cnt++;
               if ({if_lsb.P_DATA, if_lsb.par_bit} !== {e.d_lsb, e.p_lsb})
                  $display("FAIL sb_lsb: got %h/%b required %h/%b", if_lsb.P_DATA, if_lsb.par_bit, e.d_lsb, e.p_lsb);
               else pass_cnt++;
               total_cnt++;
               if ({if_msb.P_DATA, if_msb.par_bit} !== {e.d_msb, e.p_msb})
                  $display("FAIL sb_msb: got %h/%b required %h/%b", if_msb.P_DATA, if_msb.par_bit, e.d_msb, e.p_msb);
               else pass_cnt++;
               total_cnt++;
               if ({if_odd.P_DATA, if_odd.par_bit} !== {e.d_lsb, e.p_odd})
                  $display("FAIL sb_odd: got %h/%b required %h/%b", if_odd.P_DATA, if_odd.par_bit, e.d_lsb, e.p_odd);
               else pass_cnt++;
            end
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      total_cnt++;
      if ({if_lsb.P_DATA, if_msb.P_DATA, if_odd.P_DATA} !== 24'h0)
         $display("FAIL reset_pdata: got %h %h %h required 00 00 00", if_lsb.P_DATA, if_msb.P_DATA, if_odd.P_DATA);
      else pass_cnt++;
      total_cnt++;
      if ({if_lsb.data_valid, if_lsb.par_bit, if_lsb.bit_cnt, if_lsb.busy} !== 6'b0)
         $display("FAIL reset_ctrl: valid/par/cnt/busy=%b/%b/%0d/%b required 0/0/0/0",
                  if_lsb.data_valid, if_lsb.par_bit, if_lsb.bit_cnt, if_lsb.busy);
      else pass_cnt++;
      reset = 1'b0;
      cycle();
      $display("test_reset done");
   endtask

   task automatic test_lsb_basic();
      logic b[8] = '{1, 0, 0, 0, 0, 0, 1, 1};
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      total_cnt++;
      if (if_lsb.data_valid !== 1'b1)
         $display("FAIL t1_valid_hi: got %b required 1", if_lsb.data_valid);
      else pass_cnt++;
      total_cnt++;
      if ({if_lsb.P_DATA, if_lsb.par_bit, if_lsb.bit_cnt} !== {8'hC1, 1'b1, 3'd0})
         $display("FAIL t1_word: data/par/cnt=%h/%b/%0d required c1/1/0", if_lsb.P_DATA, if_lsb.par_bit, if_lsb.bit_cnt);
      else pass_cnt++;
      cycle();
      total_cnt++;
      if (if_lsb.data_valid !== 1'b0)
         $display("FAIL t1_valid_lo: got %b required 0", if_lsb.data_valid);
      else pass_cnt++;
      $display("test_lsb_basic: word c1 sent");
   endtask

   task automatic test_msb_gaps();
      logic [W-1:0] w = 8'hC1;
      for (int i = W - 1; i >= 0; i--) begin
         send_bit(w[i]);
         total_cnt++;
         if (if_msb.busy !== (i != 0))
            $display("FAIL t2_busy_bit%0d: got %b required %b", W - i, if_msb.busy, (i != 0));
         else pass_cnt++;
         if (i != 0) begin
            idle($urandom_range(0, 3));
            total_cnt++;
            if (if_msb.bit_cnt !== 3'(W - i))
               $display("FAIL t2_cnt_gap: got %0d required %0d", if_msb.bit_cnt, W - i);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if ({if_msb.P_DATA, if_msb.par_bit} !== {8'hC1, 1'b1})
         $display("FAIL t2_word: got %h/%b required c1/1", if_msb.P_DATA, if_msb.par_bit);
      else pass_cnt++;
      cycle();
      $display("test_msb_gaps: word c1 sent msb-first with gaps");
   endtask

   task automatic test_clr_abort();
      int s0 = strobe_cnt;
      send_word_lsb(8'hC1);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      clr_r = 1'b1;
      cycle();
      clr_r = 1'b0;
      cur_bits.delete();
      total_cnt++;
      if ({if_lsb.P_DATA, if_lsb.bit_cnt} !== {8'hC1, 3'd0})
         $display("FAIL t3_after_clr: data/cnt=%h/%0d required c1/0", if_lsb.P_DATA, if_lsb.bit_cnt);
      else pass_cnt++;
      for (int i = 0; i < W - 1; i++) send_bit(1'b1);
      total_cnt++;
      if (if_lsb.P_DATA !== 8'hC1)
         $display("FAIL t3_hold: got %h required c1", if_lsb.P_DATA);
      else pass_cnt++;
      send_bit(1'b1);
      cycle();
      total_cnt++;
      if ({if_lsb.P_DATA, if_lsb.par_bit} !== {8'hFF, 1'b0})
         $display("FAIL t3_ff: got %h/%b required ff/0", if_lsb.P_DATA, if_lsb.par_bit);
      else pass_cnt++;
      total_cnt++;
      if (strobe_cnt - s0 !== 2)
         $display("FAIL t3_strobes: got %0d required 2", strobe_cnt - s0);
      else pass_cnt++;
      $display("test_clr_abort: c1, aborted partial, ff");
   endtask

   task automatic test_clr_with_en();
      int s0 = strobe_cnt;
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      total_cnt++;
      if (if_lsb.bit_cnt !== 3'd5)
         $display("FAIL t4_cnt5: got %0d required 5", if_lsb.bit_cnt);
      else pass_cnt++;
      clr_r = 1'b1; en_r = 1'b1; bit_r = 1'b1;
      cycle();
      clr_r = 1'b0; en_r = 1'b0;
      cur_bits.delete();
      cycle();
      total_cnt++;
      if ({if_lsb.bit_cnt, if_lsb.P_DATA} !== {3'd0, 8'hFF} || strobe_cnt != s0)
         $display("FAIL t4_clr_en: cnt/data/strobes=%0d/%h/%0d required 0/ff/0",
                  if_lsb.bit_cnt, if_lsb.P_DATA, strobe_cnt - s0);
      else pass_cnt++;
      send_word_lsb(8'h6B);
      cycle();
      total_cnt++;
      if (if_lsb.P_DATA !== 8'h6B)
         $display("FAIL t4_next: got %h required 6b", if_lsb.P_DATA);
      else pass_cnt++;
      $display("test_clr_with_en: bit discarded, next word 6b");
   endtask

   task automatic test_reset_mid_word();
      int s0;
      send_word_lsb(8'hC1);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      s0 = strobe_cnt;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cur_bits.delete();
      cycle();
      total_cnt++;
      if ({if_lsb.P_DATA, if_msb.P_DATA, if_lsb.bit_cnt, if_lsb.par_bit} !== 20'h0 || strobe_cnt != s0)
         $display("FAIL t5_reset: data lsb/msb=%h/%h cnt=%0d par=%b strobes=%0d required 0/0/0/0/0",
                  if_lsb.P_DATA, if_msb.P_DATA, if_lsb.bit_cnt, if_lsb.par_bit, strobe_cnt - s0);
      else pass_cnt++;
      send_word_lsb(8'h3C);
      cycle();
      total_cnt++;
      if (if_lsb.P_DATA !== 8'h3C)
         $display("FAIL t5_next: got %h required 3c", if_lsb.P_DATA);
      else pass_cnt++;
      $display("test_reset_mid_word: partial dropped, next word 3c");
   endtask

   task automatic test_back_to_back();
      int n0 = strobe_cyc.size();
      logic [W-1:0] words[2] = '{8'hA5, 8'h5A};
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < W; i++) send_bit(words[k][i]);
         en_r = 1'b1;   // keep the stream continuous into the next word
         total_cnt++;
         if ({if_odd.data_valid, if_odd.P_DATA, if_odd.par_bit} !== {1'b1, words[k], 1'b1})
            $display("FAIL t6_word%0d: valid/data/par=%b/%h/%b required 1/%h/1",
                     k, if_odd.data_valid, if_odd.P_DATA, if_odd.par_bit, words[k]);
         else pass_cnt++;
      end
      en_r = 1'b0;
      cycle();
      total_cnt++;
      if (strobe_cyc.size() - n0 !== 2)
         $display("FAIL t6_count: got %0d strobes required 2", strobe_cyc.size() - n0);
      else begin
         pass_cnt++;
         total_cnt++;
         if (strobe_cyc[n0 + 1] - strobe_cyc[n0] !== 8)
            $display("FAIL t6_spacing: got %0d cycles required 8", strobe_cyc[n0 + 1] - strobe_cyc[n0]);
         else pass_cnt++;
      end
      $display("test_back_to_back: a5 then 5a continuous");
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_lsb_basic();
      test_msb_gaps();
      test_clr_abort();
      test_clr_with_en();
      test_reset_mid_word();
      test_back_to_back();
      idle(4);
      total_cnt++;
      if (exp_q.size() != 0)
         $display("FAIL sb_drain: %0d expected words never strobed", exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
